// File: rtl/regfile_read_port_skid.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_read_port_skid
//  Description : NUM_PORTS independent read ports over a flattened register bus,
//                each with a registered-ready main + skid response buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port_skid #(
    parameter int MEM_WIDTH   = 16,
    parameter int MEM_DEPTH   = 16,
    parameter int NUM_PORTS   = 2,
    parameter int ZERO_REG_EN = 1,
    localparam int AW         = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [MEM_WIDTH*MEM_DEPTH-1:0] regs_in,
    input  logic [NUM_PORTS-1:0]           req_valid,
    output logic [NUM_PORTS-1:0]           req_ready,
    input  logic [NUM_PORTS*AW-1:0]        req_addr,
    output logic [NUM_PORTS-1:0]           rsp_valid,
    input  logic [NUM_PORTS-1:0]           rsp_ready,
    output logic [NUM_PORTS*MEM_WIDTH-1:0] rsp_data,
    output logic [NUM_PORTS-1:0]           rsp_err
);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [AW-1:0]        w_addr;
        logic [MEM_WIDTH-1:0] w_rd_data;
        logic                 w_rd_err;
        logic                 w_accept;
        logic                 w_main_free;

        logic                 r_main_valid;
        logic [MEM_WIDTH-1:0] r_main_data;
        logic                 r_main_err;
        logic                 r_skid_valid;
        logic [MEM_WIDTH-1:0] r_skid_data;
        logic                 r_skid_err;
        logic                 r_req_ready;

        assign w_addr      = req_addr[p*AW +: AW];
        assign w_accept    = req_valid[p] & r_req_ready;
        assign w_main_free = ~r_main_valid | rsp_ready[p];

        // Addresses with no matching register fall through as data 0, err 1.
        always_comb begin
            w_rd_data = '0;
            w_rd_err  = 1'b1;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                if (w_addr == AW'(i)) begin
                    w_rd_err = 1'b0;
                    if (!((ZERO_REG_EN != 0) && (i == 0))) begin
                        w_rd_data = regs_in[i*MEM_WIDTH +: MEM_WIDTH];
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_main_valid <= 1'b0;
                r_main_data  <= '0;
                r_main_err   <= 1'b0;
                r_skid_valid <= 1'b0;
                r_skid_data  <= '0;
                r_skid_err   <= 1'b0;
                r_req_ready  <= 1'b1;
            end else if (r_skid_valid) begin
                // req_ready is low here, so draining the skid is the only move.
                if (rsp_ready[p]) begin
                    r_main_data  <= r_skid_data;
                    r_main_err   <= r_skid_err;
                    r_skid_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
            end else if (w_main_free) begin
                r_main_valid <= w_accept;
                if (w_accept) begin
                    r_main_data <= w_rd_data;
                    r_main_err  <= w_rd_err;
                end
            end else if (w_accept) begin
                r_skid_data  <= w_rd_data;
                r_skid_err   <= w_rd_err;
                r_skid_valid <= 1'b1;
                r_req_ready  <= 1'b0;
            end
        end

        assign req_ready[p]                       = r_req_ready;
        assign rsp_valid[p]                       = r_main_valid;
        assign rsp_data[p*MEM_WIDTH +: MEM_WIDTH] = r_main_data;
        assign rsp_err[p]                         = r_main_err;

`ifndef SYNTHESIS
        logic                 r_chk_stall;
        logic [MEM_WIDTH-1:0] r_chk_data;
        logic                 r_chk_err;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_chk_stall <= 1'b0;
                r_chk_data  <= '0;
                r_chk_err   <= 1'b0;
            end else begin
                if (r_chk_stall) begin
                    a_hold: assert (r_main_data == r_chk_data && r_main_err == r_chk_err);
                end
                a_ready:  assert (r_req_ready == !r_skid_valid);
                a_no_acc: assert (!(w_accept && r_skid_valid));
                r_chk_stall <= r_main_valid & ~rsp_ready[p];
                r_chk_data  <= r_main_data;
                r_chk_err   <= r_main_err;
            end
        end
`endif
    end

endmodule
`default_nettype wire
